// File: rtl/enigma_input_ctrl.sv
// Enigma front panel: button edge detection, rotor shadow/commit FSM, letter FIFO.
// Define ENIGMA_INPUT_SYNC_EN to put a 2-flop synchroniser on both buttons.
module enigma_input_ctrl #(
  parameter int NUM_ROTORS = 3,
  parameter int SEL_W      = 3,
  parameter int POS_W      = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          letter_valid_in,
  input  logic                          rotor_valid_in,
  input  logic [15:0]                   sw,
  input  logic                          char_ready_in,
  output logic                          rotor_valid_out,
  output logic [NUM_ROTORS*SEL_W-1:0]   rotor_select_out,
  output logic [NUM_ROTORS*POS_W-1:0]   rotor_initial_out,
  output logic [4:0]                    char_out,
  output logic                          char_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          config_done_out,
  output logic [2:0]                    error_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {CONFIG, RUN} state_t;

  state_t state;

  logic let_lvl, rot_lvl;
  logic let_prev, rot_prev;
  logic let_edge, rot_edge;

`ifdef ENIGMA_INPUT_SYNC_EN
  logic [1:0] let_sync, rot_sync;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      let_sync <= 2'b11;
      rot_sync <= 2'b11;
    end else begin
      let_sync <= {let_sync[0], letter_valid_in};
      rot_sync <= {rot_sync[0], rotor_valid_in};
    end
  end

  assign let_lvl = let_sync[1];
  assign rot_lvl = rot_sync[1];
`else
  assign let_lvl = letter_valid_in;
  assign rot_lvl = rotor_valid_in;
`endif

  // prev starts high so a button held through reset release is ignored
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      let_prev <= 1'b1;
      rot_prev <= 1'b1;
    end else begin
      let_prev <= let_lvl;
      rot_prev <= rot_lvl;
    end
  end

  assign let_edge = let_lvl & ~let_prev;
  assign rot_edge = rot_lvl & ~rot_prev;

  logic [1:0] mode;
  logic [3:0] slot;
  logic       slot_ok;
  logic       wr_pos, wr_sel, bad_idx;
  logic       do_commit, do_flush;

  assign mode      = sw[15:14];
  assign slot      = sw[11:8];
  assign slot_ok   = int'(slot) < NUM_ROTORS;
  assign wr_pos    = rot_edge & (mode == 2'b00) & slot_ok;
  assign wr_sel    = rot_edge & (mode == 2'b01) & slot_ok;
  assign bad_idx   = rot_edge & ~mode[1] & ~slot_ok;
  assign do_commit = rot_edge & (mode == 2'b10);
  assign do_flush  = rot_edge & (mode == 2'b11);

  logic [POS_W-1:0] sh_pos [NUM_ROTORS];
  logic [SEL_W-1:0] sh_sel [NUM_ROTORS];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= CONFIG;
      rotor_valid_out   <= 1'b0;
      rotor_select_out  <= '0;
      rotor_initial_out <= '0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        sh_pos[i] <= '0;
        sh_sel[i] <= '0;
      end
    end else begin
      rotor_valid_out <= do_commit;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        if (wr_pos && int'(slot) == i) sh_pos[i] <= sw[POS_W-1:0];
        if (wr_sel && int'(slot) == i) sh_sel[i] <= sw[SEL_W-1:0];
      end
      unique case (1'b1)
        do_commit: begin
          for (int i = 0; i < NUM_ROTORS; i++) begin
            rotor_select_out[i*SEL_W +: SEL_W]  <= sh_sel[i];
            rotor_initial_out[i*POS_W +: POS_W] <= sh_pos[i];
          end
          state <= RUN;
        end
        (wr_pos | wr_sel): state <= CONFIG;
        default: ;
      endcase
    end
  end

  assign config_done_out = (state == RUN);

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, letter_ok;
  logic          push_try, push, pop;
  logic          ovf, bad_let;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign letter_ok = (sw[4:0] <= 5'd25);
  // letter gating sees the state before any same-cycle config action
  assign push_try  = let_edge & (state == RUN) & letter_ok & ~do_flush;
  assign pop       = (count != '0) & char_ready_in;
  assign push      = push_try & (~full | pop);
  assign ovf       = push_try & full & ~pop;
  assign bad_let   = let_edge & ~do_flush & ((state != RUN) | ~letter_ok);

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= sw[4:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        error_out <= '0;
    else if (do_flush) error_out <= '0;
    else               error_out <= error_out | {ovf, bad_let, bad_idx};
  end

  assign char_valid_out = (count != '0);
  assign char_out       = char_valid_out ? mem[rd_ptr] : 5'd0;
  assign fifo_count_out = count;

  logic unused_sw;
  assign unused_sw = ^sw;

endmodule

// File: tb/tb_enigma_input_ctrl.sv
// Scoreboard bench for enigma_input_ctrl (default parameters).
// Letters expected out of the FIFO are queued at drive time and checked on pop.
module tb_enigma_input_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        letter_valid_in;
  logic        rotor_valid_in;
  logic [15:0] sw;
  logic        char_ready_in;
  logic        rotor_valid_out;
  logic [8:0]  rotor_select_out;
  logic [14:0] rotor_initial_out;
  logic [4:0]  char_out;
  logic        char_valid_out;
  logic [3:0]  fifo_count_out;
  logic        config_done_out;
  logic [2:0]  error_out;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  logic [31:0] exp_q [$];

  always #5 clk_in = ~clk_in;

  enigma_input_ctrl dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .letter_valid_in   (letter_valid_in),
    .rotor_valid_in    (rotor_valid_in),
    .sw                (sw),
    .char_ready_in     (char_ready_in),
    .rotor_valid_out   (rotor_valid_out),
    .rotor_select_out  (rotor_select_out),
    .rotor_initial_out (rotor_initial_out),
    .char_out          (char_out),
    .char_valid_out    (char_valid_out),
    .fifo_count_out    (fifo_count_out),
    .config_done_out   (config_done_out),
    .error_out         (error_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cfg(input logic [1:0] m,
                                      input logic [3:0] s,
                                      input logic [7:0] v);
    return {m, 2'b00, s, v};
  endfunction

  // idle cycle, one-cycle press, release; returns just after the action edge
  task automatic press(input bit r, input bit l, input logic [15:0] s);
    @(negedge clk_in);
    sw = s;
    rotor_valid_in = r;
    letter_valid_in = l;
    @(negedge clk_in);
    rotor_valid_in = 1'b0;
    letter_valid_in = 1'b0;
  endtask

  always @(negedge clk_in) begin
    #1;
    if (!rst_in) begin
      if (rotor_valid_out) pulses++;
      if (char_valid_out && char_ready_in) begin
        logic [31:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 32'hdead;
        chk("fifo_data", {27'd0, char_out}, e);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && fifo_count_out != 0; i++) @(negedge clk_in);
    #1 chk("drain_count", fifo_count_out, 0);
  endtask

  initial begin
    rst_in = 1'b1;
    letter_valid_in = 1'b0;
    rotor_valid_in = 1'b0;
    sw = '0;
    char_ready_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_valid", rotor_valid_out, 0);
    chk("rst_sel", rotor_select_out, 0);
    chk("rst_init", rotor_initial_out, 0);
    chk("rst_cvalid", char_valid_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_done", config_done_out, 0);
    chk("rst_err", error_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    press(0, 1, 16'd7);
    #1 chk("cfg_letter_err", error_out, 3'b010);
    chk("cfg_letter_cnt", fifo_count_out, 0);

    press(1, 0, cfg(2'b11, 0, 0));
    #1 chk("flush_err", error_out, 0);

    press(1, 0, cfg(2'b00, 0, 5));
    press(1, 0, cfg(2'b00, 2, 17));
    press(1, 0, cfg(2'b01, 1, 4));
    #1 chk("shadow_init", rotor_initial_out, 0);
    chk("shadow_sel", rotor_select_out, 0);
    press(1, 0, cfg(2'b10, 0, 0));
    #1 chk("commit_pulse", rotor_valid_out, 1);
    chk("commit_init", rotor_initial_out, (17 << 10) | 5);
    chk("commit_sel", rotor_select_out, 4 << 3);
    chk("commit_done", config_done_out, 1);
    @(negedge clk_in);
    #1 chk("pulse_end", rotor_valid_out, 0);

    exp_q.push_back(7);
    press(0, 1, 16'd7);
    #1 chk("l7_char", char_out, 7);
    chk("l7_valid", char_valid_out, 1);
    chk("l7_count", fifo_count_out, 1);
    drain();

    char_ready_in = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(i);
      press(0, 1, 16'(i));
    end
    #1 chk("full_count", fifo_count_out, 8);
    chk("ovf_flag", error_out[2], 1);
    @(negedge clk_in);
    sw = 16'd20;
    letter_valid_in = 1'b1;
    char_ready_in = 1'b1;
    exp_q.push_back(20);
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    #1 chk("full_pushpop_cnt", fifo_count_out, 8);
    drain();
    chk("q_after_drain", exp_q.size(), 0);

    press(1, 0, cfg(2'b11, 0, 0));
    press(1, 0, cfg(2'b00, 3, 9));
    #1 chk("badidx_err", error_out, 3'b001);
    chk("badidx_init", rotor_initial_out, (17 << 10) | 5);
    chk("badidx_sel", rotor_select_out, 4 << 3);

    press(0, 1, 16'd26);
    #1 chk("badlet_err", error_out, 3'b011);
    chk("badlet_cnt", fifo_count_out, 0);

    press(1, 0, cfg(2'b00, 1, 30));
    #1 chk("rewrite_done", config_done_out, 0);
    chk("rewrite_init", rotor_initial_out, (17 << 10) | 5);
    press(1, 0, cfg(2'b10, 0, 0));
    #1 chk("recommit_init", rotor_initial_out, (17 << 10) | (30 << 5) | 5);
    chk("recommit_done", config_done_out, 1);

    char_ready_in = 1'b0;
    exp_q.push_back(1);
    press(0, 1, 16'd1);
    exp_q.push_back(2);
    press(0, 1, 16'd2);
    #1 chk("pre_flush_cnt", fifo_count_out, 2);
    press(1, 1, cfg(2'b11, 0, 3));
    exp_q.delete();
    #1 chk("flush_cnt", fifo_count_out, 0);
    chk("flush_noerr", error_out, 0);

    press(1, 0, cfg(2'b00, 0, 5));
    press(1, 1, cfg(2'b10, 0, 4));
    #1 chk("sim_done", config_done_out, 1);
    chk("sim_pulse", rotor_valid_out, 1);
    chk("sim_cnt", fifo_count_out, 0);
    chk("sim_err", error_out, 3'b010);

    @(negedge clk_in);
    sw = 16'd12;
    letter_valid_in = 1'b1;
    exp_q.push_back(12);
    repeat (100) @(negedge clk_in);
    letter_valid_in = 1'b0;
    #1 chk("hold_cnt", fifo_count_out, 1);
    for (int i = 13; i <= 15; i++) begin
      exp_q.push_back(i);
      press(0, 1, 16'(i));
    end
    #1 chk("run4_cnt", fifo_count_out, 4);

    #1;
    rst_in = 1'b1;
    sw = cfg(2'b10, 0, 0);
    rotor_valid_in = 1'b1;
    letter_valid_in = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_valid", rotor_valid_out, 0);
    chk("arst_sel", rotor_select_out, 0);
    chk("arst_init", rotor_initial_out, 0);
    chk("arst_char", char_out, 0);
    chk("arst_cvalid", char_valid_out, 0);
    chk("arst_cnt", fifo_count_out, 0);
    chk("arst_done", config_done_out, 0);
    chk("arst_err", error_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    pulses = 0;
    repeat (5) @(negedge clk_in);
    #1 chk("held_pulses", pulses, 0);
    chk("held_done", config_done_out, 0);
    chk("held_err", error_out, 0);
    rotor_valid_in = 1'b0;
    letter_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1 chk("held_cnt", fifo_count_out, 0);

    press(1, 0, cfg(2'b10, 0, 0));
    #1 chk("post_pulse", rotor_valid_out, 1);
    chk("post_init", rotor_initial_out, 0);
    chk("post_done", config_done_out, 1);

    chk("q_final", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
